// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and types.
// Imported by the fetch stage and its PC incrementer.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

endpackage

// File: rtl/pc_incr.sv
// Sequential PC incrementer.
// Wraps modulo 2^32.
module pc_incr #(
  parameter int unsigned STEP = 4
) (
  input  logic [31:0] a,
  output logic [31:0] y
);

  assign y = a + 32'(STEP);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select, IF/ID register.
// Redirects flush IF/ID for one bubble.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] pc
);

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] redirect_pc;
  logic        redirect;

  pc_incr #(
    .STEP (PC_STEP)
  ) u_pc_incr (
    .a (pc),
    .y (pc_plus4)
  );

  assign imem_addr   = pc;
  assign jump_target = {pc_plus4[31:28], jump_index, 2'b00};
  assign redirect    = jump | branch_taken;
  assign ifid_valid  = (state == RUN);

  // Jump outranks branch when both fire.
  always_comb begin
    redirect_pc = branch_target & ~32'd3;
    if (jump) begin
      redirect_pc = jump_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      state         <= BUBBLE;
    end else if (redirect) begin
      pc            <= redirect_pc;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      state         <= BUBBLE;
    end else if (!stall) begin
      pc            <= pc_plus4;
      ifid_instr    <= imem_rdata;
      ifid_pc_plus4 <= pc_plus4;
      state         <= RUN;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns the bitwise
// inverse of its address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .pc            (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc,
                         input logic [31:0] e_instr,
                         input logic [31:0] e_pp4,
                         input logic e_valid);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".addr"}, imem_addr, e_pc);
    chk({tag, ".instr"}, ifid_instr, e_instr);
    chk({tag, ".pp4"}, ifid_pc_plus4, e_pp4);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_index    = '0;
    step();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    reset = 1'b0;
    step();
    chk_all("run1", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);
    step();
    chk_all("run2", 32'h8, 32'hFFFF_FFFB, 32'h8, 1'b1);

    stall = 1'b1;
    step();
    chk_all("stall1", 32'h8, 32'hFFFF_FFFB, 32'h8, 1'b1);
    step();
    chk_all("stall2", 32'h8, 32'hFFFF_FFFB, 32'h8, 1'b1);
    stall = 1'b0;
    step();
    chk_all("resume", 32'hC, 32'hFFFF_FFF7, 32'hC, 1'b1);
    step();
    chk_all("run3", 32'h10, 32'hFFFF_FFF3, 32'h10, 1'b1);

    branch_taken  = 1'b1;
    branch_target = 32'h0000_0043;
    step();
    chk_all("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    step();
    chk_all("after_br", 32'h44, 32'hFFFF_FFBF, 32'h44, 1'b1);

    branch_taken  = 1'b1;
    branch_target = 32'h1000_0000;
    step();
    chk_all("br_hi", 32'h1000_0000, 32'h0, 32'h0, 1'b0);

    jump          = 1'b1;
    jump_index    = 26'h000_0010;
    branch_target = 32'h0000_0080;
    step();
    chk_all("jump_wins", 32'h1000_0040, 32'h0, 32'h0, 1'b0);

    branch_taken = 1'b0;
    stall        = 1'b1;
    jump_index   = 26'h000_0020;
    step();
    chk_all("stall_jump", 32'h1000_0080, 32'h0, 32'h0, 1'b0);

    jump          = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    chk_all("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    step();
    chk_all("wrap", 32'h0, 32'h0000_0003, 32'h0, 1'b1);
    step();
    chk_all("post_wrap", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);

    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    reset         = 1'b1;
    step();
    chk_all("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
    reset        = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    step();
    chk_all("rst_fetch", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
